atm_session_ctrl: RTL

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

---
 rtl/atm_pkg.sv | 25 ++
 rtl/atm_idle_timer.sv | 34 +++
 rtl/atm_session_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state, request-op and response-code encodings for the ATM session controller
package atm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BIO_WAIT = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_LOCKED   = 2'd3
    } state_e;

    localparam logic [1:0] OP_LOGIN      = 2'b00;
    localparam logic [1:0] OP_WITHDRAW   = 2'b01;
    localparam logic [1:0] OP_CHANGE_PIN = 2'b10;
    localparam logic [1:0] OP_LOGOUT     = 2'b11;

    localparam logic [2:0] RSP_OK       = 3'd0;
    localparam logic [2:0] RSP_BAD_PIN  = 3'd1;
    localparam logic [2:0] RSP_LOCKED   = 3'd2;
    localparam logic [2:0] RSP_BAD_AMT  = 3'd3;
    localparam logic [2:0] RSP_LIMIT    = 3'd4;
    localparam logic [2:0] RSP_SAME_PIN = 3'd5;
    localparam logic [2:0] RSP_TIMEOUT  = 3'd6;
    localparam logic [2:0] RSP_BAD_OP   = 3'd7;

endpackage

// File: rtl/atm_idle_timer.sv
// rtl/atm_idle_timer.sv - session inactivity counter; expire_o pulses on the TIMEOUT_CYC-th enabled cycle
module atm_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A clear in the expiry cycle suppresses the expiry: the request wins
    assign expire_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || !enable_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session FSM: PIN login, biometric gate, withdraw/change-PIN, lockout, idle timeout
// Optional daily withdrawal ceiling and day_rollover clear enabled by defining ATM_DAILY_LIMIT_EN.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int               PIN_W        = 4,
    parameter int               AMT_W        = 8,
    parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'hA,
    parameter int               MAX_ATTEMPTS = 3,
    parameter int               MAX_TXN      = 100,
    parameter int               DAILY_LIMIT  = 200,
    parameter int               TIMEOUT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [PIN_W-1:0] req_pin,
    input  logic [PIN_W-1:0] req_new_pin,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             bio_ok,
    input  logic             day_rollover,
    output logic             rsp_valid,
    output logic [2:0]       rsp_code,
    output logic             session_active,
    output logic             account_locked,
    output logic [AMT_W:0]   daily_total
);
    localparam int              AW        = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [AW-1:0]   MAX_ATT   = AW'(MAX_ATTEMPTS);
    localparam logic [AMT_W:0]  MAX_TXN_W = (AMT_W + 1)'(MAX_TXN);

    state_e             state_q;
    logic [PIN_W-1:0]   pin_q;
    logic [AW-1:0]      att_q;
    logic [AMT_W:0]     total_q;
    logic               rsp_valid_q;
    logic [2:0]         rsp_code_q;

    logic               accept;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_expire;
    logic [AW-1:0]      att_inc_d;
    logic               lock_d;
    logic               pin_ok;
    logic               amt_bad;
    logic               over_limit_d;
    logic [AMT_W:0]     total_d;

    assign req_ready      = (state_q != ST_BIO_WAIT);
    assign accept         = req_valid && req_ready;
    assign timer_en       = (state_q == ST_BIO_WAIT) || (state_q == ST_ACTIVE);
    assign timer_clear    = accept || ((state_q == ST_BIO_WAIT) && bio_ok);
    assign att_inc_d      = att_q + AW'(1);
    assign lock_d         = (att_inc_d == MAX_ATT);
    assign pin_ok         = (req_pin == pin_q);
    assign amt_bad        = (req_amount == '0) || ((AMT_W + 1)'(req_amount) > MAX_TXN_W);

`ifdef ATM_DAILY_LIMIT_EN
    localparam int              SW        = AMT_W + 2;
    localparam logic [SW-1:0]   DAILY_W   = SW'(DAILY_LIMIT);
    logic [AMT_W:0]     total_base_d;
    logic [SW-1:0]      sum_d;
    // A rollover in the same cycle as a withdrawal is applied before the limit check
    assign total_base_d   = day_rollover ? '0 : total_q;
    assign sum_d          = SW'(total_base_d) + SW'(req_amount);
    assign over_limit_d   = (sum_d > DAILY_W);
    assign total_d        = total_base_d + (AMT_W + 1)'(req_amount);
`else
    logic               unused_rollover;
    assign unused_rollover = day_rollover;
    assign over_limit_d   = 1'b0;
    assign total_d        = '0;
`endif

    atm_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pin_q       <= DEFAULT_PIN;
            att_q       <= '0;
            total_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_OK;
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
            if (day_rollover) begin
                total_q <= '0;
            end
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_op == OP_LOGIN && pin_ok) begin
                            att_q   <= '0;
                            state_q <= ST_BIO_WAIT;
                        end else if (req_op == OP_LOGIN) begin
                            att_q       <= att_inc_d;
                            rsp_valid_q <= 1'b1;
                            rsp_code_q  <= lock_d ? RSP_LOCKED : RSP_BAD_PIN;
                            if (lock_d) state_q <= ST_LOCKED;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_code_q  <= RSP_BAD_OP;
                        end
                    end
                end
                ST_BIO_WAIT: begin
                    if (bio_ok) begin
                        state_q     <= ST_ACTIVE;
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_OK;
                    end else if (timer_expire) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_TIMEOUT;
                    end
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        rsp_valid_q <= 1'b1;
                        unique case (req_op)
                            OP_WITHDRAW: begin
                                if (amt_bad) begin
                                    rsp_code_q <= RSP_BAD_AMT;
                                end else if (over_limit_d) begin
                                    rsp_code_q <= RSP_LIMIT;
                                end else begin
                                    rsp_code_q <= RSP_OK;
`ifdef ATM_DAILY_LIMIT_EN
                                    total_q    <= total_d;
`endif
                                end
                            end
                            OP_CHANGE_PIN: begin
                                if (!pin_ok) begin
                                    att_q      <= att_inc_d;
                                    rsp_code_q <= lock_d ? RSP_LOCKED : RSP_BAD_PIN;
                                    if (lock_d) state_q <= ST_LOCKED;
                                end else if (req_new_pin == pin_q) begin
                                    rsp_code_q <= RSP_SAME_PIN;
                                end else begin
                                    pin_q      <= req_new_pin;
                                    rsp_code_q <= RSP_OK;
                                end
                            end
                            OP_LOGOUT: begin
                                state_q    <= ST_IDLE;
                                rsp_code_q <= RSP_OK;
                            end
                            default: begin
                                rsp_code_q <= RSP_BAD_OP;
                            end
                        endcase
                    end else if (timer_expire) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_TIMEOUT;
                    end
                end
                default: begin
                    if (accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_LOCKED;
                    end
                end
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_code       = rsp_code_q;
    assign session_active = (state_q == ST_ACTIVE);
    assign account_locked = (state_q == ST_LOCKED);
    assign daily_total    = total_q;

endmodule
